// File: rtl/pixel_write_buffer_pkg.sv
// Shared types for the pixel write buffer: FIFO entry layout and drain FSM states.
package pixel_write_buffer_pkg;

    localparam int PIX_ADDR_W = 32;
    localparam int PIX_DATA_W = 16;

    typedef struct packed {
        logic [PIX_ADDR_W-1:0] address;
        logic [PIX_DATA_W-1:0] color;
    } pixel_write_t;

    typedef enum logic {
        PWB_IDLE,
        PWB_WRITE
    } pwb_state_t;

endpackage

// File: rtl/pixel_write_buffer_sync_fifo.sv
// Synchronous FIFO with registered storage; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module pixel_write_buffer_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;
    T            mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign rdata = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer advance; reset empties the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full)
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop && !empty)
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // Entry storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (!reset && push && !full)
            mem_q[wr_ptr_q[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Buffers shaded pixels and drains them as single 16-bit Avalon-MM writes on m1.
// level counts stored entries plus the one held in the m1 registers, so
// drained only fires once the fabric has accepted every pixel.
module pixel_write_buffer
    import pixel_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = PIX_ADDR_W,
    parameter int DATA_W = PIX_DATA_W,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [ADDR_W-1:0] pix_address,
    input  logic [DATA_W-1:0] pix_color,
    input  logic              flush,
    output logic              drained,
    output logic              busy,
    output logic [LW-1:0]     level,
    output logic              addr_error,
    output logic [ADDR_W-1:0] m1_address,
    output logic [DATA_W-1:0] m1_writedata,
    output logic              m1_write,
    input  logic              m1_waitrequest
);

    pwb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] m1_address_q, m1_address_d;
    logic [DATA_W-1:0] m1_writedata_q, m1_writedata_d;
    logic [LW-1:0]     level_q, level_d;
    logic              flush_pending_q, flush_pending_d;
    logic              addr_error_q, addr_error_d;

    pixel_write_t fifo_wdata, fifo_rdata;
    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic         handshake, accept;

    // Full FIFO implies level == DEPTH, so the fifo_full term never changes pix_ready.
    assign pix_ready  = (level_q < LW'(DEPTH)) && !fifo_full;
    assign handshake  = pix_valid && pix_ready;
    assign fifo_push  = handshake && !pix_address[0];
    assign fifo_wdata = '{address: pix_address, color: pix_color};
    assign accept     = (state_q == PWB_WRITE) && !m1_waitrequest;

    assign m1_write     = (state_q == PWB_WRITE);
    assign m1_address   = m1_address_q;
    assign m1_writedata = m1_writedata_q;
    assign level        = level_q;
    assign busy         = (level_q != '0);
    assign drained      = flush_pending_q && (level_q == '0);
    assign addr_error   = addr_error_q;

    pixel_write_buffer_sync_fifo #(
        .DEPTH(DEPTH),
        .T    (pixel_write_t)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (fifo_push),
        .wdata(fifo_wdata),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Drain FSM: load the FIFO head into the m1 registers and hold it until accepted.
    always_comb begin
        state_d        = state_q;
        m1_address_d   = m1_address_q;
        m1_writedata_d = m1_writedata_q;
        fifo_pop       = 1'b0;
        case (state_q)
            PWB_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    m1_address_d   = fifo_rdata.address;
                    m1_writedata_d = fifo_rdata.color;
                    state_d        = PWB_WRITE;
                end
            end
            PWB_WRITE: begin
                if (accept) begin
                    if (!fifo_empty) begin
                        fifo_pop       = 1'b1;
                        m1_address_d   = fifo_rdata.address;
                        m1_writedata_d = fifo_rdata.color;
                    end else begin
                        state_d = PWB_IDLE;
                    end
                end
            end
            default: state_d = PWB_IDLE;
        endcase
    end

    // Occupancy, flush tracking and sticky misalignment flag.
    always_comb begin
        level_d         = level_q + LW'(fifo_push) - LW'(accept);
        flush_pending_d = drained ? 1'b0 : (flush_pending_q || flush);
        addr_error_d    = addr_error_q || (handshake && pix_address[0]);
    end

    // State register; reset drops the in-flight write along with the FIFO contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= PWB_IDLE;
            m1_address_q    <= '0;
            m1_writedata_q  <= '0;
            level_q         <= '0;
            flush_pending_q <= 1'b0;
            addr_error_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            m1_address_q    <= m1_address_d;
            m1_writedata_q  <= m1_writedata_d;
            level_q         <= level_d;
            flush_pending_q <= flush_pending_d;
            addr_error_q    <= addr_error_d;
        end
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer with hand-computed expectations.
module tb_pixel_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] pix_address;
    logic [15:0] pix_color;
    logic        flush;
    logic        drained;
    logic        busy;
    logic [3:0]  level;
    logic        addr_error;
    logic [31:0] m1_address;
    logic [15:0] m1_writedata;
    logic        m1_write;
    logic        m1_waitrequest;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pixel_write_buffer #(.DEPTH(8), .ADDR_W(32), .DATA_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_address   (pix_address),
        .pix_color     (pix_color),
        .flush         (flush),
        .drained       (drained),
        .busy          (busy),
        .level         (level),
        .addr_error    (addr_error),
        .m1_address    (m1_address),
        .m1_writedata  (m1_writedata),
        .m1_write      (m1_write),
        .m1_waitrequest(m1_waitrequest)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    localparam logic [31:0] BASE2 = 32'h0800_1000;
    localparam logic [31:0] BASE3 = 32'h0800_2000;
    localparam logic [31:0] BASE4 = 32'h0800_3000;
    localparam logic [31:0] BASE6 = 32'h0800_4000;

    initial begin
        int idx;
        logic rdy;

        reset = 1'b1; pix_valid = 1'b0; pix_address = '0; pix_color = '0;
        flush = 1'b0; m1_waitrequest = 1'b0;
        step; step;
        check("rst_write", m1_write, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", pix_ready, 1);
        check("rst_drained", drained, 0);
        check("rst_addr_err", addr_error, 0);
        check("rst_m1_addr", m1_address, 0);
        check("rst_m1_data", m1_writedata, 0);
        reset = 1'b0;

        // single pixel
        pix_valid = 1'b1; pix_address = 32'h0800_0004; pix_color = 16'h1111;
        step;
        pix_valid = 1'b0;
        check("t1_level_stored", level, 1);
        check("t1_no_write_yet", m1_write, 0);
        step;
        check("t1_write", m1_write, 1);
        check("t1_addr", m1_address, 32'h0800_0004);
        check("t1_data", m1_writedata, 16'h1111);
        check("t1_level_inflight", level, 1);
        step;
        check("t1_write_done", m1_write, 0);
        check("t1_level_empty", level, 0);
        check("t1_busy_low", busy, 0);

        // back-to-back, one write per cycle
        pix_valid = 1'b1; pix_address = BASE2; pix_color = 16'h2000;
        for (int n = 0; n < 10; n++) begin
            step;
            if (n + 1 < 8) begin
                pix_address = BASE2 + 32'(2 * (n + 1));
                pix_color   = 16'h2000 + 16'(n + 1);
            end else begin
                pix_valid = 1'b0;
            end
            if (n < 8) check("t2_ready", pix_ready, 1);
            if (n >= 1 && n <= 8) begin
                check("t2_write", m1_write, 1);
                check("t2_addr", m1_address, BASE2 + 32'(2 * (n - 1)));
                check("t2_data", m1_writedata, 16'h2000 + 16'(n - 1));
            end else begin
                check("t2_write_idle", m1_write, 0);
            end
        end
        check("t2_level_end", level, 0);

        // stall until full, then release
        m1_waitrequest = 1'b1;
        idx = 0;
        pix_valid = 1'b1; pix_address = BASE3; pix_color = 16'h3000;
        for (int n = 0; n < 20; n++) begin
            rdy = pix_ready;
            step;
            if (rdy) begin
                idx++;
                pix_address = BASE3 + 32'(2 * idx);
                pix_color   = 16'h3000 + 16'(idx);
            end
            if (n >= 1) begin
                check("t3_hold_addr", m1_address, BASE3);
                check("t3_hold_data", m1_writedata, 16'h3000);
                check("t3_hold_write", m1_write, 1);
            end
            if (n == 7 || n == 19) begin
                check("t3_level_full", level, 8);
                check("t3_ready_low", pix_ready, 0);
            end
        end
        check("t3_pushed", idx, 8);
        pix_valid = 1'b0;
        m1_waitrequest = 1'b0;
        for (int n = 20; n < 28; n++) begin
            step;
            if (n == 20) check("t3_ready_back", pix_ready, 1);
            if (n <= 26) begin
                check("t3_write", m1_write, 1);
                check("t3_addr", m1_address, BASE3 + 32'(2 * (n - 19)));
                check("t3_data", m1_writedata, 16'h3000 + 16'(n - 19));
            end else begin
                check("t3_write_idle", m1_write, 0);
                check("t3_level_end", level, 0);
            end
        end

        // flush with toggling waitrequest
        m1_waitrequest = 1'b1;
        pix_valid = 1'b1; pix_address = BASE4; pix_color = 16'h4000;
        step;
        pix_address = BASE4 + 32'd2; pix_color = 16'h4001;
        step;
        pix_address = BASE4 + 32'd4; pix_color = 16'h4002;
        step;
        pix_valid = 1'b0;
        flush = 1'b1;
        step;
        flush = 1'b0;
        for (int n = 3; n <= 10; n++) begin
            check("t4_drained", drained, (n == 8));
            if (n == 4) check("t4_next_addr", m1_address, BASE4 + 32'd2);
            if (n == 8) check("t4_level_zero", level, 0);
            m1_waitrequest = (n > 7 || (n % 2) == 1) ? 1'b0 : 1'b1;
            flush = (n == 5);
            step;
        end
        check("t4_drained_quiet", drained, 0);
        flush = 1'b1;
        step;
        flush = 1'b0;
        check("t4_empty_flush", drained, 1);
        step;
        check("t4_empty_flush_end", drained, 0);

        // misaligned pixel is consumed but dropped
        m1_waitrequest = 1'b0;
        pix_valid = 1'b1; pix_address = 32'h0800_0003; pix_color = 16'hBAD0;
        check("t5_ready", pix_ready, 1);
        step;
        pix_valid = 1'b0;
        check("t5_addr_err", addr_error, 1);
        check("t5_level", level, 0);
        check("t5_busy", busy, 0);
        step;
        check("t5_no_write", m1_write, 0);
        pix_valid = 1'b1; pix_address = 32'h0800_0010; pix_color = 16'h5555;
        step;
        pix_valid = 1'b0;
        step;
        check("t5_good_write", m1_write, 1);
        check("t5_good_addr", m1_address, 32'h0800_0010);
        check("t5_good_data", m1_writedata, 16'h5555);
        step;
        check("t5_good_done", m1_write, 0);
        check("t5_addr_err_sticky", addr_error, 1);

        // reset while writes are stalled and a flush is pending
        m1_waitrequest = 1'b1;
        pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix_address = BASE6 + 32'(2 * i);
            pix_color   = 16'h6000 + 16'(i);
            flush       = (i == 0);
            step;
        end
        pix_valid = 1'b0; flush = 1'b0;
        check("t6_level_before", level, 4);
        check("t6_write_before", m1_write, 1);
        reset = 1'b1;
        step;
        check("t6_write", m1_write, 0);
        check("t6_level", level, 0);
        check("t6_ready", pix_ready, 1);
        check("t6_drained", drained, 0);
        check("t6_busy", busy, 0);
        check("t6_addr_err", addr_error, 0);
        reset = 1'b0;
        m1_waitrequest = 1'b0;
        step;
        check("t6_no_stale_drain", drained, 0);
        check("t6_idle", m1_write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
- Sits between the shader array and the GPU's Avalon-MM pixel master port (m1).
- Accepts shaded pixels (byte address, RGB565 colour) over a valid/ready interface and buffers them in a FIFO.
- Drains the FIFO to OCRAM/pixel memory as single 16-bit Avalon writes, honouring m1_waitrequest.
- Provides a flush/drained handshake so the command controller raises its IRQ only after every pixel write has been accepted by the fabric.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
ADDR_W, 32, m1 byte-address width
DATA_W, 16, pixel width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_valid  in  1  shader presents a pixel
pix_ready  out  1  buffer can accept; transfer when valid && ready
pix_address  in  ADDR_W  pixel byte address
pix_color  in  DATA_W  pixel colour
flush  in  1  one-cycle pulse: request drained notification
drained  out  1  one-cycle pulse: flush complete
busy  out  1  FIFO non-empty or write in flight
level  out  $clog2(DEPTH)+1  current occupancy, including the in-flight entry
addr_error  out  1  sticky: a misaligned pixel was dropped
m1_address  out  ADDR_W  Avalon address
m1_writedata  out  DATA_W  Avalon write data
m1_write  out  1  Avalon write strobe
m1_waitrequest  in  1  Avalon stall

Behaviour:
Clocking and reset
- All state updates on posedge clock.
- reset is synchronous, active-high, and dominates everything else.
- Reset values: pointers 0, level 0, m1_write 0, m1_address 0, m1_writedata 0, drained 0, busy 0, addr_error 0, flush_pending 0.
- Reset mid-write drops the in-flight entry and all buffered entries.

Input side
- pix_ready = (level < DEPTH). No same-cycle bypass when full.
- Push occurs on pix_valid && pix_ready.
- If pix_address[0] == 1, the pixel is consumed (handshake completes) but not stored, and addr_error is set sticky. It is cleared only by reset.

Output state machine
- IDLE: if the FIFO is non-empty, pop the head into the m1 registers, assert m1_write, go to WRITE. Output latency is one cycle from push into an empty buffer to m1_write high.
- WRITE:
  - m1_address and m1_writedata are held stable while m1_waitrequest = 1.
  - Accept occurs on m1_write && !m1_waitrequest.
  - On accept with the FIFO non-empty: load the next entry the same cycle and stay in WRITE, so m1_write stays high for back-to-back writes (one write per cycle at full throughput).
  - On accept with the FIFO empty: deassert m1_write, go to IDLE.

Occupancy
- level = stored entries + (m1_write ? 1 : 0).
- level rises on push and falls on accept.
- Simultaneous push and accept leaves level unchanged.
- pix_ready uses the registered level, so a full buffer with an accepting fabric still shows ready = 0 that cycle.
- busy = (level != 0).

Flush
- flush sets flush_pending.
- drained pulses high for exactly one cycle on the first cycle where flush_pending && level == 0. This includes the cycle after flush if already empty. flush_pending clears on that same cycle.
- flush while flush_pending is already set: no additional effect.
- Pushes after flush are counted until drained; drained waits for them.

Avalon rules
- m1_write is never asserted with stale data.
- An m1_waitrequest held high indefinitely stalls the buffer with no loss; pix_ready falls once full.

Decomposition:
- gpu package gets typedef pixel_write_t {logic [ADDR_W-1:0] address; logic [DATA_W-1:0] color;} and the enum pwb_state_t {PWB_IDLE, PWB_WRITE}.
- Sub-module sync_fifo (DEPTH, type T):
  - registered storage with wrapping pointers plus an extra wrap bit;
  - push/pop/full/empty, first-word available combinationally.
- pixel_write_buffer instantiates one sync_fifo and holds the state machine, level counter and flush logic.

Test Plan:
1. Single pixel, waitrequest=0: push (0x08000004, 0x1111) → next cycle m1_write=1, addr 0x08000004, data 0x1111 for one cycle; level 1→0; busy falls.
2. Back-to-back: push 8 pixels at one per cycle with waitrequest=0 → 8 consecutive m1 write cycles, in order, no gaps; pix_ready stays 1.
3. Stall/full: waitrequest=1 for 20 cycles while pushing → pix_ready=0 once level=8, m1 address/data stable; after release all 8 writes appear in order and pix_ready rises.
4. Flush: push 3, pulse flush, waitrequest toggles 1/0 → drained single pulse only on the cycle after the 3rd accept; flush when empty → drained the next cycle.
5. Misaligned: push address 0x08000003 → handshake completes, no m1 write, addr_error=1 and stays 1 after later good writes.
6. Reset mid-write: 4 queued, waitrequest=1, assert reset → next cycle m1_write=0, level=0, pix_ready=1, drained=0.
